// File: rtl/pwm_capture.sv
// pwm_capture
//   Input-capture block at the measuring end of the PWM path. It samples an
//   asynchronous PWM input and reports the period (rising to rising) and the
//   high time (rising to falling). Both are counted in prescaled timebase ticks.
//
// Ports
//   clk            system clock
//   rst_n          asynchronous reset, active low
//   pwm_in         asynchronous PWM input
//   capture_en     1 = measure, 0 = idle
//   capture_reset  synchronous soft reset of the measurement state
//   prescale[7:0]  timebase exponent; one tick every 2^prescale clk cycles
//   period_val     last rising-to-rising interval, in ticks
//   high_val       last rising-to-falling interval, in ticks
//   measure_valid  one-cycle pulse when period_val/high_val update
//   timeout        sticky: no rising edge within 0xFFFF ticks
//   level          synchronized pwm_in
module pwm_capture #(
  parameter int MAX_PRESCALE = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pwm_in,
  input  logic        capture_en,
  input  logic        capture_reset,
  input  logic [7:0]  prescale,
  output logic [15:0] period_val,
  output logic [15:0] high_val,
  output logic        measure_valid,
  output logic        timeout,
  output logic        level
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [7:0] MAX_P8 = 8'(MAX_PRESCALE);
  localparam logic [3:0] MAX_P4 = 4'(MAX_PRESCALE);

  state_t      state, state_next;
  logic        s1, s2, s3;
  logic        rise, fall;
  logic [3:0]  active_prescale;
  logic [3:0]  prescale_clamped;
  logic [15:0] pcnt;
  logic [15:0] cnt;
  logic [15:0] hcap;
  logic        fall_seen;
  logic [15:0] limit_m1;
  logic        tick;
  logic [16:0] cnt_plus;
  logic [15:0] cnt_tick;
  logic        sat_timeout;
  logic        load_prescale;

  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
  assign level = s2;

  assign prescale_clamped = (prescale > MAX_P8) ? MAX_P4 : prescale[3:0];

  // Tick marks the last prescaler count of each 2^active_prescale window.
  assign limit_m1 = 16'((17'd1 << active_prescale) - 17'd1);
  assign tick     = (pcnt == limit_m1);

  // Interval including the tick of the current cycle. It saturates
  // instead of wrapping when the count is already at 0xFFFF.
  assign cnt_plus = {1'b0, cnt} + {16'd0, tick};
  assign cnt_tick = cnt_plus[16] ? 16'hFFFF : cnt_plus[15:0];

  // A rise in the same cycle as counter saturation counts as a valid measurement.
  assign sat_timeout = (state == MEASURE) && (cnt == 16'hFFFF) && tick && !rise;

  // The prescale input only takes effect at window boundaries.
  assign load_prescale = (state == IDLE) || capture_reset || rise;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; the soft reset and the enable override the window flow
  always_comb begin
    state_next = state;
    if (capture_reset) begin
      state_next = capture_en ? ARM : IDLE;
    end else if (!capture_en) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = ARM;
        ARM:     if (rise) state_next = MEASURE;
        MEASURE: if (sat_timeout) state_next = ARM;
        default: state_next = IDLE;
      endcase
    end
  end

  // Synchronizer, prescaler, interval counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1              <= 1'b0;
      s2              <= 1'b0;
      s3              <= 1'b0;
      active_prescale <= 4'd0;
      pcnt            <= 16'd0;
      cnt             <= 16'd0;
      hcap            <= 16'd0;
      fall_seen       <= 1'b0;
      period_val      <= 16'd0;
      high_val        <= 16'd0;
      measure_valid   <= 1'b0;
      timeout         <= 1'b0;
    end else begin
      s1            <= pwm_in;
      s2            <= s1;
      s3            <= s2;
      measure_valid <= 1'b0;
      if (load_prescale) active_prescale <= prescale_clamped;

      if (capture_reset) begin
        pcnt       <= 16'd0;
        cnt        <= 16'd0;
        hcap       <= 16'd0;
        fall_seen  <= 1'b0;
        period_val <= 16'd0;
        high_val   <= 16'd0;
        timeout    <= 1'b0;
      end else if (!capture_en || state == IDLE) begin
        pcnt      <= 16'd0;
        cnt       <= 16'd0;
        fall_seen <= 1'b0;
        timeout   <= 1'b0;
      end else if (state == ARM) begin
        pcnt      <= 16'd0;
        cnt       <= 16'd0;
        fall_seen <= 1'b0;
      end else begin
        if (rise) begin
          period_val    <= cnt_tick;
          high_val      <= fall_seen ? hcap : cnt_tick;
          measure_valid <= 1'b1;
          pcnt          <= 16'd0;
          cnt           <= 16'd0;
          fall_seen     <= 1'b0;
        end else if (sat_timeout) begin
          timeout    <= 1'b1;
          period_val <= 16'd0;
          high_val   <= s2 ? 16'hFFFF : 16'd0;
          pcnt       <= 16'd0;
          cnt        <= 16'd0;
          fall_seen  <= 1'b0;
        end else begin
          if (fall) begin
            hcap      <= cnt_tick;
            fall_seen <= 1'b1;
          end
          if (tick) begin
            pcnt <= 16'd0;
            cnt  <= cnt + 16'd1;
          end else begin
            pcnt <= pcnt + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture. Every scenario task drives its own
// stimulus and compares against hand-computed values.
module tb_pwm_capture;

  logic        clk;
  logic        rst_n;
  logic        pwm_in;
  logic        capture_en;
  logic        capture_reset;
  logic [7:0]  prescale;
  logic [15:0] period_val;
  logic [15:0] high_val;
  logic        measure_valid;
  logic        timeout;
  logic        level;

  int testsRun;
  int testsFailed;
  int validCount;
  logic [15:0] lastPeriod;
  logic [15:0] lastHigh;

  pwm_capture #(.MAX_PRESCALE(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pwm_in        (pwm_in),
    .capture_en    (capture_en),
    .capture_reset (capture_reset),
    .prescale      (prescale),
    .period_val    (period_val),
    .high_val      (high_val),
    .measure_valid (measure_valid),
    .timeout       (timeout),
    .level         (level)
  );

  // 10 MHz clock
  initial clk = 1'b0;
  always #50 clk = ~clk;

  // Record every valid pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (measure_valid) begin
      validCount <= validCount + 1;
      lastPeriod <= period_val;
      lastHigh   <= high_val;
    end
  end

  // Hold pwm_in at a value for n clock edges; returns 1 time unit after an edge
  task automatic drive(input logic v, input int n);
    pwm_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pwm_period(input int hi, input int lo);
    drive(1'b1, hi);
    drive(1'b0, lo);
  endtask

  task automatic do_reset(input logic [7:0] ps);
    rst_n = 1'b0;
    pwm_in = 1'b0;
    capture_en = 1'b0;
    capture_reset = 1'b0;
    prescale = ps;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    do_reset(8'd0);
    testsRun++;
    if (period_val !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_period got %0d want 0", period_val); end
    testsRun++;
    if (high_val !== 16'd0) begin testsFailed++; $display("[TB] FAIL reset_high got %0d want 0", high_val); end
    testsRun++;
    if ({measure_valid, timeout, level} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL reset_flags got %b want 000", {measure_valid, timeout, level});
    end
  endtask

  // prescale 0, period 10, high 3; checks pulse latency and values
  task automatic test_basic;
    int c0;
    do_reset(8'd0);
    capture_en = 1'b1;
    drive(1'b0, 3);
    c0 = validCount;
    pwm_period(3, 7);
    drive(1'b1, 2);
    testsRun++;
    if (measure_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL basic_early_valid got %b want 0", measure_valid); end
    drive(1'b1, 1);
    testsRun++;
    if (measure_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_latency_valid got %b want 1", measure_valid); end
    testsRun++;
    if (period_val !== 16'd10 || high_val !== 16'd3) begin
      testsFailed++; $display("[TB] FAIL basic_first got %0d/%0d want 10/3", period_val, high_val);
    end
    drive(1'b0, 7);
    for (int i = 0; i < 3; i++) pwm_period(3, 7);
    drive(1'b1, 4);
    testsRun++;
    if (validCount - c0 !== 5) begin testsFailed++; $display("[TB] FAIL basic_pulse_count got %0d want 5", validCount - c0); end
    testsRun++;
    if (lastPeriod !== 16'd10 || lastHigh !== 16'd3) begin
      testsFailed++; $display("[TB] FAIL basic_values got %0d/%0d want 10/3", lastPeriod, lastHigh);
    end
    testsRun++;
    if (level !== 1'b1) begin testsFailed++; $display("[TB] FAIL basic_level got %b want 1", level); end
  endtask

  // prescale 1, period 100, high 50; prescale changes mid-window
  task automatic test_prescale;
    do_reset(8'd1);
    capture_en = 1'b1;
    drive(1'b0, 3);
    pwm_period(50, 50);
    pwm_period(50, 50);
    testsRun++;
    if (lastPeriod !== 16'd50 || lastHigh !== 16'd25) begin
      testsFailed++; $display("[TB] FAIL prescale1 got %0d/%0d want 50/25", lastPeriod, lastHigh);
    end
    drive(1'b1, 20);
    prescale = 8'd2;
    drive(1'b1, 30);
    drive(1'b0, 50);
    pwm_period(50, 50);
    testsRun++;
    if (lastPeriod !== 16'd50 || lastHigh !== 16'd25) begin
      testsFailed++; $display("[TB] FAIL prescale_midwindow got %0d/%0d want 50/25", lastPeriod, lastHigh);
    end
    pwm_period(50, 50);
    testsRun++;
    if (lastPeriod !== 16'd25 || lastHigh !== 16'd12) begin
      testsFailed++; $display("[TB] FAIL prescale2 got %0d/%0d want 25/12", lastPeriod, lastHigh);
    end
  endtask

  // pwm_in held high after one rise: saturation timeout
  task automatic test_timeout;
    int k;
    int c0;
    do_reset(8'd0);
    capture_en = 1'b1;
    drive(1'b0, 3);
    c0 = validCount;
    drive(1'b1, 1);
    k = 0;
    while (timeout !== 1'b1 && k < 70000) begin
      @(posedge clk);
      #1;
      k++;
    end
    testsRun++;
    if (k !== 65538) begin testsFailed++; $display("[TB] FAIL timeout_cycle got %0d want 65538", k); end
    testsRun++;
    if (period_val !== 16'd0 || high_val !== 16'hFFFF) begin
      testsFailed++; $display("[TB] FAIL timeout_values got %h/%h want 0000/ffff", period_val, high_val);
    end
    testsRun++;
    if (validCount != c0) begin testsFailed++; $display("[TB] FAIL timeout_no_pulse got %0d want 0", validCount - c0); end
    drive(1'b0, 5);
    pwm_period(3, 7);
    testsRun++;
    if (validCount != c0) begin testsFailed++; $display("[TB] FAIL timeout_arm got %0d want 0", validCount - c0); end
    drive(1'b1, 4);
    testsRun++;
    if (validCount - c0 !== 1 || lastPeriod !== 16'd10 || lastHigh !== 16'd3 || timeout !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL timeout_recover got n=%0d %0d/%0d to=%b want n=1 10/3 to=1", validCount - c0, lastPeriod, lastHigh, timeout);
    end
    drive(1'b0, 6);
  endtask

  // capture_reset mid-window clears results and re-arms
  task automatic test_soft_reset;
    int c0;
    do_reset(8'd0);
    capture_en = 1'b1;
    drive(1'b0, 3);
    pwm_period(3, 7);
    pwm_period(4, 8);
    drive(1'b1, 4);
    drive(1'b0, 2);
    capture_reset = 1'b1;
    drive(1'b0, 1);
    capture_reset = 1'b0;
    testsRun++;
    if (period_val !== 16'd0 || high_val !== 16'd0 || timeout !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL softreset_clear got %0d/%0d to=%b want 0/0 to=0", period_val, high_val, timeout);
    end
    drive(1'b0, 4);
    c0 = validCount;
    pwm_period(3, 7);
    testsRun++;
    if (validCount != c0) begin testsFailed++; $display("[TB] FAIL softreset_arm got %0d want 0", validCount - c0); end
    drive(1'b1, 4);
    testsRun++;
    if (validCount - c0 !== 1 || lastPeriod !== 16'd10 || lastHigh !== 16'd3) begin
      testsFailed++; $display("[TB] FAIL softreset_second got n=%0d %0d/%0d want n=1 10/3", validCount - c0, lastPeriod, lastHigh);
    end
    drive(1'b0, 6);
  endtask

  // capture_en dropped mid-window
  task automatic test_enable_abort;
    int c0;
    do_reset(8'd0);
    capture_en = 1'b1;
    drive(1'b0, 3);
    pwm_period(3, 7);
    pwm_period(3, 7);
    drive(1'b1, 3);
    drive(1'b0, 2);
    c0 = validCount;
    capture_en = 1'b0;
    drive(1'b0, 5);
    pwm_period(3, 7);
    testsRun++;
    if (validCount != c0) begin testsFailed++; $display("[TB] FAIL abort_no_pulse got %0d want 0", validCount - c0); end
    testsRun++;
    if (period_val !== 16'd10 || high_val !== 16'd3 || timeout !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL abort_hold got %0d/%0d to=%b want 10/3 to=0", period_val, high_val, timeout);
    end
    capture_en = 1'b1;
    drive(1'b0, 2);
    pwm_period(4, 8);
    testsRun++;
    if (validCount != c0) begin testsFailed++; $display("[TB] FAIL reenable_arm got %0d want 0", validCount - c0); end
    pwm_period(4, 8);
    testsRun++;
    if (validCount - c0 !== 1 || lastPeriod !== 16'd12 || lastHigh !== 16'd4) begin
      testsFailed++; $display("[TB] FAIL reenable_pulse got n=%0d %0d/%0d want n=1 12/4", validCount - c0, lastPeriod, lastHigh);
    end
  endtask

  // rst_n asserted between clock edges
  task automatic test_async_reset;
    drive(1'b1, 3);
    @(posedge clk);
    #20;
    rst_n = 1'b0;
    #5;
    testsRun++;
    if (period_val !== 16'd0 || high_val !== 16'd0) begin
      testsFailed++; $display("[TB] FAIL async_reset_values got %0d/%0d want 0/0", period_val, high_val);
    end
    testsRun++;
    if ({measure_valid, timeout, level} !== 3'b000) begin
      testsFailed++; $display("[TB] FAIL async_reset_flags got %b want 000", {measure_valid, timeout, level});
    end
    #10;
    rst_n = 1'b1;
    pwm_in = 1'b0;
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    validCount = 0;
    lastPeriod = 16'd0;
    lastHigh = 16'd0;
    test_reset();
    test_basic();
    test_prescale();
    test_soft_reset();
    test_enable_abort();
    test_timeout();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
